axi_burst_mem_slave: RTL and testbench
======================================

# axi_burst_mem_slave

AXI4 burst slave that turns memory-mapped INCR bursts into single-word accesses on the dual-port memory (separate write port and registered read port) in the AXI_MM_BURST subsystem. It is the responder end of the burst interface: it accepts AW/W and AR bursts from a master, drives the memory's write and read ports beat by beat, and returns B responses and R data with AXI valid/ready handshakes.

## Interface
- DATA_WIDTH, 8, data width in bits of the AXI data and of one memory word.
- ADDR_WIDTH, 10, width of the word address on AXI and on the memory.
- clk  in  1  single clock; every port is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  word address of the first write beat.
- s_axi_awlen  in  8  write beats minus 1 (1..256 beats).
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wlast  in  1  final write beat marker from the master.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_WIDTH  word address of the first read beat.
- s_axi_arlen  in  8  read beats minus 1.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rlast  out  1  final read beat marker.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- mem_write_en  out  1  memory write strobe.
- mem_write_address  out  ADDR_WIDTH  memory write address.
- mem_data_in  out  DATA_WIDTH  memory write data.
- mem_read_en  out  1  memory read strobe.
- mem_read_address  out  ADDR_WIDTH  memory read address.
- mem_data_out  in  DATA_WIDTH  memory read data, valid the cycle after mem_read_en.

## Operation
- Bursts are INCR only and word-addressed. The address increments by 1 per beat and wraps modulo 2^ADDR_WIDTH; address 2^ADDR_WIDTH-1 is followed by 0.
- The write and read FSMs are independent and may be active at the same time. Only one burst per channel is outstanding.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. An AW handshake captures the address and len, clears the beat counter, and moves to W_DATA.
  - W_DATA: wready=1. mem_write_en = wvalid. mem_write_address is the current address and mem_data_in = wdata, both combinational.
  - Each W handshake increments the address and beat counter. The beat with counter==len moves the FSM to W_RESP.
  - bresp=SLVERR if wlast was seen on any beat other than the final one, or was missing on the final beat; otherwise OKAY. The burst always consumes exactly len+1 beats.
  - W_RESP: bvalid=1 is held until bready, then the FSM returns to W_IDLE.
- Read FSM, R_IDLE -> R_READ -> R_DATA:
  - R_IDLE: arready=1. An AR handshake captures the address and len and moves to R_READ.
  - R_READ: mem_read_en=1 for one cycle at the current address, then move to R_DATA.
  - R_DATA: rvalid=1, rdata = mem_data_out (the memory holds its output while read_en is low), and rlast = (counter==len).
  - On an R handshake: if rlast, go to R_IDLE; otherwise increment the address and counter and go to R_READ.
- A read and a write to the same address in the same cycle returns the old data.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, arready=0, rvalid=0, rlast=0, rdata=0, mem_write_en=0, mem_read_en=0, both memory addresses=0, mem_data_in=0. The FSMs are in W_IDLE/R_IDLE, so awready and arready rise in the first cycle after reset is released.
- Reset asserted mid-burst aborts both FSMs in the next cycle. No B or R beat is produced and memory contents are untouched.
- Write throughput: 1 beat per cycle. The first write can occur the cycle after the AW handshake. bvalid rises the cycle after the last W handshake.
- Read throughput: 1 beat per 2 cycles. The first rvalid is 2 cycles after the AR handshake.
- Once asserted, rvalid, rdata and rlast are held stable until rready. bvalid and bresp are likewise held stable until bready.
- awready=0 outside W_IDLE and arready=0 outside R_IDLE.

## Test plan
- AW addr=0x010, len=3, W 0xA1..0xA4 with wlast on the 4th beat and bready=1 -> memory addresses 0x010..0x013 hold A1..A4; bresp=00 one cycle after the last beat.
- AR addr=0x010, len=3, rready=1 -> R returns A1,A2,A3,A4, rlast only on A4, first rvalid 2 cycles after the AR handshake.
- Write at addr=0x3FE, len=2 (3 beats) -> writes land at 0x3FE, 0x3FF, 0x000; a read burst of the same shape returns the same data.
- Write len=1 with wlast on beat 1 -> 2 beats are still written and bresp=2'b10.
- Read len=2 with rready toggling 1/0 each cycle -> rdata is stable while stalled; exactly 3 beats arrive in order. A concurrent write burst to other addresses completes without affecting the read.
- rst pulsed during beat 2 of a 4-beat write -> all outputs return to their reset values; a following burst completes normally.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_burst_mem_slave
//
// AXI4 INCR burst responder in front of a dual-port memory (one write port,
// one registered read port). Write bursts are streamed into the memory at one
// beat per cycle. Read bursts use one memory read followed by one R beat, so
// they deliver one beat every two cycles. The write and read channels are
// independent, and each channel has at most one burst outstanding.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   s_axi_aw*            : write address channel (word address, len = beats-1)
//   s_axi_w*             : write data channel (wlast is checked, not trusted)
//   s_axi_b*             : write response (00 OKAY, 10 SLVERR on wlast error)
//   s_axi_ar*            : read address channel
//   s_axi_r*             : read data channel
//   mem_write_*          : memory write port (en, address, data)
//   mem_read_*           : memory read port (en, address)
//   mem_data_out         : memory read data, valid the cycle after mem_read_en
// ---------------------------------------------------------------------------
module axi_burst_mem_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;

    // ---------------- write channel ----------------
    w_state_t              r_w_state;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wcnt;
    logic                  r_werr;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_w_final;
    logic w_wlast_bad;

    assign w_aw_hs     = s_axi_awvalid & r_awready;
    assign w_w_hs      = s_axi_wvalid & r_wready;
    assign w_w_final   = (r_wcnt == r_wlen);
    // wlast must be present on the final beat and absent on all others.
    assign w_wlast_bad = (s_axi_wlast != w_w_final);

    // NOTE: sequential state uses non-blocking assignments only; where a
    // register gets a default and a later override in the same branch, the
    // last non-blocking assignment wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_state <= W_IDLE;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_waddr   <= s_axi_awaddr;
                        r_wlen    <= s_axi_awlen;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr <= r_waddr + 1'b1;  // wraps modulo 2^ADDR_WIDTH
                        r_wcnt  <= r_wcnt + 8'd1;
                        if (w_wlast_bad) r_werr <= 1'b1;
                        // The beat count alone ends the burst; wlast only
                        // affects the response code.
                        if (w_w_final) begin
                            r_wready  <= 1'b0;
                            r_bvalid  <= 1'b1;
                            r_bresp   <= (r_werr | w_wlast_bad) ? 2'b10 : 2'b00;
                            r_w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_awready <= 1'b1;
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    assign s_axi_awready     = r_awready;
    assign s_axi_wready      = r_wready;
    assign s_axi_bvalid      = r_bvalid;
    assign s_axi_bresp       = r_bresp;
    // The strobe is masked by rst so a beat presented while reset is asserted
    // never reaches the memory.
    assign mem_write_en      = r_wready & s_axi_wvalid & ~rst;
    assign mem_write_address = r_waddr;
    assign mem_data_in       = r_wready ? s_axi_wdata : '0;

    // ---------------- read channel ----------------
    r_state_t              r_r_state;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rcnt;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rd_en;

    logic w_ar_hs;
    logic w_rlast;

    assign w_ar_hs = s_axi_arvalid & r_arready;
    assign w_rlast = r_rvalid & (r_rcnt == r_rlen);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_state <= R_IDLE;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_raddr   <= s_axi_araddr;
                        r_rlen    <= s_axi_arlen;
                        r_rcnt    <= '0;
                        r_arready <= 1'b0;
                        r_rd_en   <= 1'b1;
                        r_r_state <= R_READ;
                    end
                end
                R_READ: begin
                    // Memory output becomes valid now and is held by the
                    // memory until the next read strobe.
                    r_rd_en   <= 1'b0;
                    r_rvalid  <= 1'b1;
                    r_r_state <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        if (w_rlast) begin
                            r_arready <= 1'b1;
                            r_r_state <= R_IDLE;
                        end else begin
                            r_raddr   <= r_raddr + 1'b1;
                            r_rcnt    <= r_rcnt + 8'd1;
                            r_rd_en   <= 1'b1;
                            r_r_state <= R_READ;
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready    = r_arready;
    assign s_axi_rvalid     = r_rvalid;
    assign s_axi_rlast      = w_rlast;
    assign s_axi_rdata      = r_rvalid ? mem_data_out : '0;
    assign mem_read_en      = r_rd_en & ~rst;
    assign mem_read_address = r_raddr;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_mem_slave
//
// Bench for axi_burst_mem_slave with a behavioural dual-port memory (registered
// read, read-before-write). Expected memory writes, R beats and B responses are
// queued when stimulus is driven and compared on the falling edge when the DUT
// produces them.
// ---------------------------------------------------------------------------
module tb_axi_burst_mem_slave;

    localparam int DW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic          s_axi_wlast;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic          mem_write_en;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_read_en;
    logic [AW-1:0] mem_read_address;
    logic [DW-1:0] mem_data_out;

    always #5 clk = ~clk;

    axi_burst_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axi_awaddr      (s_axi_awaddr),
        .s_axi_awlen       (s_axi_awlen),
        .s_axi_awvalid     (s_axi_awvalid),
        .s_axi_awready     (s_axi_awready),
        .s_axi_wdata       (s_axi_wdata),
        .s_axi_wlast       (s_axi_wlast),
        .s_axi_wvalid      (s_axi_wvalid),
        .s_axi_wready      (s_axi_wready),
        .s_axi_bresp       (s_axi_bresp),
        .s_axi_bvalid      (s_axi_bvalid),
        .s_axi_bready      (s_axi_bready),
        .s_axi_araddr      (s_axi_araddr),
        .s_axi_arlen       (s_axi_arlen),
        .s_axi_arvalid     (s_axi_arvalid),
        .s_axi_arready     (s_axi_arready),
        .s_axi_rdata       (s_axi_rdata),
        .s_axi_rlast       (s_axi_rlast),
        .s_axi_rvalid      (s_axi_rvalid),
        .s_axi_rready      (s_axi_rready),
        .mem_write_en      (mem_write_en),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in),
        .mem_read_en       (mem_read_en),
        .mem_read_address  (mem_read_address),
        .mem_data_out      (mem_data_out)
    );

    // ---------------- memory model and reference image ----------------
    logic          preload;
    logic [DW-1:0] mem     [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i) ^ 8'h5A;
            mem_data_out <= '0;
        end else begin
            if (mem_write_en) mem[mem_write_address] <= mem_data_in;
            if (mem_read_en)  mem_data_out <= mem[mem_read_address];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } w_exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } r_exp_t;

    w_exp_t     w_q[$];
    r_exp_t     r_q[$];
    logic [1:0] b_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    w_exp_t        w_e;
    r_exp_t        r_e;
    logic [1:0]    b_e;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_l;

    always @(negedge clk) begin
        if (mem_write_en) begin
            if (w_q.size() == 0) check("w_unexpected", 1, 0);
            else begin
                w_e = w_q.pop_front();
                check("w_addr", mem_write_address, w_e.addr);
                check("w_data", mem_data_in, w_e.data);
            end
        end
        if (s_axi_rvalid && s_axi_rready) begin
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
                r_e = r_q.pop_front();
                check("r_data", s_axi_rdata, r_e.data);
                check("r_last", s_axi_rlast, r_e.last);
            end
        end
        if (s_axi_bvalid && s_axi_bready) begin
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else begin
                b_e = b_q.pop_front();
                check("b_resp", s_axi_bresp, b_e);
            end
        end
        // An R beat stalled last cycle must be presented again unchanged.
        if (hold_v && !rst) begin
            check("r_hold_valid", s_axi_rvalid, 1);
            check("r_hold_data", s_axi_rdata, hold_d);
            check("r_hold_last", s_axi_rlast, hold_l);
        end
        hold_v = s_axi_rvalid && !s_axi_rready && !rst;
        hold_d = s_axi_rdata;
        hold_l = s_axi_rlast;
    end

    // ---------------- stimulus tasks ----------------
    task automatic check_reset_outs(input string tag);
        check(tag, {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                    s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rdata,
                    mem_write_en, mem_read_en, mem_write_address,
                    mem_read_address, mem_data_in}, 64'd0);
    endtask

    // Write burst of len+1 beats, data base+i, wlast on beat wlast_beat (-1: never).
    task automatic wr_burst(input logic [AW-1:0] addr, input int len,
                            input logic [DW-1:0] base, input int wlast_beat);
        int            n;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 50);
        check("aw_ready", s_axi_awready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        b_q.push_back((wlast_beat == len) ? 2'b00 : 2'b10);
        for (int i = 0; i <= len; i++) begin
            a = addr + AW'(i);
            s_axi_wdata  = base + DW'(i);
            s_axi_wlast  = (i == wlast_beat);
            s_axi_wvalid = 1'b1;
            w_q.push_back(w_exp_t'{addr: a, data: s_axi_wdata});
            ref_mem[a] = s_axi_wdata;
            @(negedge clk);
            check("w_ready", s_axi_wready, 1);
            if (i == 0) check("aw_busy", s_axi_awready, 0);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        @(negedge clk);
        check("b_latency", s_axi_bvalid, 1);
        n = 0;
        while (s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_done", s_axi_bvalid, 0);
    endtask

    // Read burst of len+1 beats; with toggle set rready alternates 1/0 per cycle.
    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input bit toggle);
        int            n;
        int            cyc;
        int            got;
        int            first;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 50);
        check("ar_ready", s_axi_arready, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        for (int i = 0; i <= len; i++) begin
            a = addr + AW'(i);
            r_q.push_back(r_exp_t'{data: ref_mem[a], last: (i == len)});
        end
        cyc = 0; got = 0; first = 0;
        while (got < len + 1 && cyc < 4 * (len + 1) + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("ar_busy", s_axi_arready, 0);
            if (s_axi_rvalid && first == 0) first = cyc;
            if (s_axi_rvalid && s_axi_rready) got++;
            @(posedge clk); #1;
            if (toggle) s_axi_rready = ~s_axi_rready;
        end
        s_axi_rready = 1'b1;
        check("r_first_latency", first, 2);
        check("r_beat_count", got, len + 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; preload = 1'b1;
        s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = 8'hFF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i) ^ 8'h5A;

        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_outputs");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("awready_after_reset", s_axi_awready, 1);
        check("arready_after_reset", s_axi_arready, 1);

        // Basic 4-beat write, then read it back.
        wr_burst(10'h010, 3, 8'hA1, 3);
        for (int i = 0; i < 4; i++) check("mem_0x010", mem[10'h010 + i], 8'hA1 + DW'(i));
        rd_burst(10'h010, 3, 1'b0);

        // Address wrap at the top of the space.
        wr_burst(10'h3FE, 2, 8'hB1, 2);
        check("mem_0x3fe", mem[10'h3FE], 8'hB1);
        check("mem_0x3ff", mem[10'h3FF], 8'hB2);
        check("mem_0x000", mem[10'h000], 8'hB3);
        rd_burst(10'h3FE, 2, 1'b0);

        // wlast protocol errors: early wlast, missing wlast.
        wr_burst(10'h030, 1, 8'hE1, 0);
        wr_burst(10'h020, 2, 8'hD1, -1);
        rd_burst(10'h030, 1, 1'b0);
        rd_burst(10'h020, 2, 1'b0);

        // Stalled read concurrent with a write burst elsewhere.
        fork
            rd_burst(10'h3FE, 2, 1'b1);
            wr_burst(10'h200, 4, 8'h51, 4);
        join
        rd_burst(10'h200, 4, 1'b0);

        // Reset during beat 2 of a 4-beat write.
        @(posedge clk); #1;
        s_axi_awaddr = 10'h100; s_axi_awlen = 8'd3; s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 50);
        check("aw_ready_abort", s_axi_awready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 8'hC1; s_axi_wvalid = 1'b1;
        w_q.push_back(w_exp_t'{addr: 10'h100, data: 8'hC1});
        ref_mem[10'h100] = 8'hC1;
        @(posedge clk); #1;
        s_axi_wdata = 8'hC2; rst = 1'b1;
        @(negedge clk);
        check("no_write_in_reset", mem_write_en, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outs("reset_outputs_midburst");
        @(posedge clk); #1;
        rst = 1'b0; s_axi_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        check("mem_0x101_untouched", mem[10'h101], 8'h01 ^ 8'h5A);
        wr_burst(10'h104, 3, 8'hC5, 3);
        rd_burst(10'h100, 7, 1'b0);

        // Maximum length burst (256 beats), wrapping past the top.
        wr_burst(10'h380, 255, 8'h80, 255);
        rd_burst(10'h380, 255, 1'b0);

        repeat (5) @(posedge clk);
        check("w_queue_empty", w_q.size(), 0);
        check("r_queue_empty", r_q.size(), 0);
        check("b_queue_empty", b_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
